// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//   Plays a melody stored in a small song RAM. Each RAM entry is
//   {note[7:4], beats[3:0]}; the sequencer steps through the entries and
//   drives a single programmable tone divider whose divisor is looked up
//   from the note index (octave 3, C3..B3 = 1..12, all other indices rest).
//
//   Optional feature macro: LOOP_EN
//     defined   -> adds input `loop`; a completed song restarts at step 0
//                  (done still pulses once per pass) until `stop`.
//     undefined -> no `loop` port; completion always returns to idle.
//
// Ports
//   clock_in   in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins playback at step 0 (idle only)
//   stop       in   one-cycle pulse, aborts playback (wins over start)
//   wr_en      in   song RAM write strobe, honoured only while idle
//   wr_addr    in   song RAM write address
//   wr_data    in   {note[7:4], beats[3:0]}; beats == 0 marks end of song
//   loop       in   (LOOP_EN only) restart at step 0 after completion
//   busy       out  high while a song is being played
//   done       out  one-cycle pulse on normal completion
//   step       out  index of the entry now playing
//   note_out   out  note index now playing (0 = rest)
//   clock_out  out  square-wave tone to the speaker
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BEAT_TICKS = 12_500_000,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DIV_W      = 28
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
`ifdef LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step,
    output logic [3:0]        note_out,
    output logic              clock_out
);

    localparam int unsigned NUM_STEPS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_STEP = '1;
    localparam logic [DIV_W-1:0]  BEAT_TICKS_W = DIV_W'(BEAT_TICKS);

    // Clock expressed in centi-hertz so note frequencies stay integral.
    localparam logic [63:0] CLK_CHZ = 64'(CLK_HZ) * 64'd100;

    // Rounded divisor for a frequency given in centi-hertz (elaboration only).
    function automatic logic [DIV_W-1:0] div_of(input logic [63:0] f_chz);
        return DIV_W'((CLK_CHZ + (f_chz >> 1)) / f_chz);
    endfunction

    localparam logic [DIV_W-1:0] DIV_C3  = div_of(64'd13081);
    localparam logic [DIV_W-1:0] DIV_CS3 = div_of(64'd13859);
    localparam logic [DIV_W-1:0] DIV_D3  = div_of(64'd14683);
    localparam logic [DIV_W-1:0] DIV_DS3 = div_of(64'd15556);
    localparam logic [DIV_W-1:0] DIV_E3  = div_of(64'd16481);
    localparam logic [DIV_W-1:0] DIV_F3  = div_of(64'd17461);
    localparam logic [DIV_W-1:0] DIV_FS3 = div_of(64'd18500);
    localparam logic [DIV_W-1:0] DIV_G3  = div_of(64'd19600);
    localparam logic [DIV_W-1:0] DIV_GS3 = div_of(64'd20765);
    localparam logic [DIV_W-1:0] DIV_A3  = div_of(64'd22000);
    localparam logic [DIV_W-1:0] DIV_AS3 = div_of(64'd23308);
    localparam logic [DIV_W-1:0] DIV_B3  = div_of(64'd24694);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [3:0]        note_q, note_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  beat_q, beat_d;
    logic [DIV_W-1:0]  limit_q, limit_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clk_out_q, clk_out_d;

    logic [7:0]        mem [NUM_STEPS];
    logic [7:0]        rd_data_c;
    logic [3:0]        rd_note_c;
    logic [3:0]        rd_beats_c;
    logic [DIV_W-1:0]  div_val_c;
    logic [DIV_W-1:0]  div_last_c;
    logic [DIV_W-1:0]  half_c;
    logic              tone_c;
    logic              loop_c;

`ifdef LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    // Song RAM: not reset, written only while the sequencer is idle.
    always_ff @(posedge clock_in) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c  = mem[step_q];
    assign rd_note_c  = rd_data_c[7:4];
    assign rd_beats_c = rd_data_c[3:0];

    // Divisor for the latched note; rests select zero and keep the tone low.
    always_comb begin
        div_val_c = '0;
        case (note_q)
            4'd1:    div_val_c = DIV_C3;
            4'd2:    div_val_c = DIV_CS3;
            4'd3:    div_val_c = DIV_D3;
            4'd4:    div_val_c = DIV_DS3;
            4'd5:    div_val_c = DIV_E3;
            4'd6:    div_val_c = DIV_F3;
            4'd7:    div_val_c = DIV_FS3;
            4'd8:    div_val_c = DIV_G3;
            4'd9:    div_val_c = DIV_GS3;
            4'd10:   div_val_c = DIV_A3;
            4'd11:   div_val_c = DIV_AS3;
            4'd12:   div_val_c = DIV_B3;
            default: div_val_c = '0;
        endcase
    end

    assign tone_c     = (note_q != 4'd0) && (note_q <= 4'd12);
    assign div_last_c = div_val_c - DIV_W'(1);
    assign half_c     = div_val_c >> 1;

    // State register and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            note_q    <= '0;
            div_q     <= '0;
            beat_q    <= '0;
            limit_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            note_q    <= note_d;
            div_q     <= div_d;
            beat_q    <= beat_d;
            limit_q   <= limit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clk_out_q <= clk_out_d;
        end
    end

    // Next-state and next-output logic; outputs are derived from state_d so
    // they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        note_d    = note_q;
        div_d     = div_q;
        beat_d    = beat_q;
        limit_d   = limit_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        clk_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    step_d  = '0;
                end
            end
            ST_LOAD: begin
                note_d = rd_note_c;
                if (rd_beats_c == 4'd0) begin
                    state_d = ST_FINISH;
                end else begin
                    div_d   = '0;
                    beat_d  = '0;
                    limit_d = DIV_W'(rd_beats_c) * BEAT_TICKS_W - DIV_W'(1);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Registered compare gives the one-cycle lag on clock_out.
                clk_out_d = tone_c && (div_q < half_c);
                div_d     = (div_q == div_last_c) ? '0 : div_q + DIV_W'(1);
                if (beat_q == limit_q) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = step_q + ADDR_W'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    beat_d = beat_q + DIV_W'(1);
                end
            end
            ST_FINISH: begin
                if (loop_c) begin
                    state_d = ST_LOAD;
                    step_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort has priority over every transition above, including start.
        if (stop) begin
            state_d = ST_IDLE;
            div_d   = '0;
            beat_d  = '0;
        end

        if (state_d == ST_IDLE) begin
            step_d    = '0;
            note_d    = '0;
            clk_out_d = 1'b0;
        end

        if (state_d == ST_FINISH) begin
            clk_out_d = 1'b0;
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_PLAY) ||
                 ((state_d == ST_FINISH) && loop_c);
        done_d = (state_d == ST_FINISH);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign step      = step_q;
    assign note_out  = note_q;
    assign clock_out = clk_out_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//   Randomised and directed stimulus for melody_sequencer. The driver keeps a
//   song-level reference model (RAM image plus the cycle from which the
//   sequencer is idle) and, for every accepted start, queues the complete
//   cycle-by-cycle output trace of the song. A separate monitor pops and
//   compares one expected entry per clock on the falling edge.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int BT     = 8;
    localparam int NSTEPS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [3:0] wr_addr_i = '0;
    logic [7:0] wr_data_i = '0;
    logic       loop_m = 1'b0;

    logic       busy_o;
    logic       done_o;
    logic [3:0] step_o;
    logic [3:0] note_o;
    logic       clk_o;

    melody_sequencer #(
        .BEAT_TICKS(BT)
    ) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .start    (start_i),
        .stop     (stop_i),
        .wr_en    (wr_en_i),
        .wr_addr  (wr_addr_i),
        .wr_data  (wr_data_i),
`ifdef LOOP_EN
        .loop     (loop_m),
`endif
        .busy     (busy_o),
        .done     (done_o),
        .step     (step_o),
        .note_out (note_o),
        .clock_out(clk_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic [3:0] step;
        logic [3:0] note;
        logic       clk;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         idle_from = 0;
    int         checks = 0;
    int         errors = 0;
    bit         end_req = 1'b0;
    logic [7:0] mram [NSTEPS];

    always @(posedge clk) cyc <= cyc + 1;

    // Note divisor from the musical frequency of octave 3 at 50 MHz.
    function automatic int note_div(input int n);
        real f;
        case (n)
            1: f = 130.81;  2: f = 138.59;  3: f = 146.83;  4: f = 155.56;
            5: f = 164.81;  6: f = 174.61;  7: f = 185.00;  8: f = 196.00;
            9: f = 207.65; 10: f = 220.00; 11: f = 233.08; 12: f = 246.94;
            default: f = 1.0;
        endcase
        return $rtoi(50.0e6 / f + 0.5);
    endfunction

    // Square wave level k cycles into a note: high for the first half period.
    function automatic bit tone_at(input int n, input int k);
        int d;
        if (n < 1 || n > 12) return 1'b0;
        d = note_div(n);
        return (k % d) < (d / 2);
    endfunction

    task automatic push(input int t, input bit b, input bit d, input int s,
                        input int n, input bit co);
        exp_t e;
        e.cyc  = t;
        e.busy = b;
        e.done = d;
        e.step = 4'(s);
        e.note = 4'(n);
        e.clk  = co;
        sb.push_back(e);
    endtask

    // Full expected trace of one playback started in cycle c.
    task automatic gen_trace(input int c);
        int t, prev_note, note, beats, len, passes;
        bit prev_clk, ended;
        t = c + 1;
        prev_note = 0;
        prev_clk = 1'b0;
        passes = loop_m ? 8 : 1;
        for (int p = 0; p < passes; p++) begin
            ended = 1'b0;
            for (int s = 0; s < NSTEPS && !ended; s++) begin
                note  = int'(mram[s][7:4]);
                beats = int'(mram[s][3:0]);
                push(t, 1'b1, 1'b0, s, prev_note, prev_clk);
                t++;
                if (beats == 0) begin
                    push(t, loop_m, 1'b1, s, note, 1'b0);
                    t++;
                    prev_note = note;
                    prev_clk = 1'b0;
                    ended = 1'b1;
                end else begin
                    len = beats * BT;
                    for (int k = 0; k < len; k++) begin
                        push(t, 1'b1, 1'b0, s, note, (k == 0) ? 1'b0 : tone_at(note, k - 1));
                        t++;
                    end
                    prev_note = note;
                    prev_clk = tone_at(note, len - 1);
                end
            end
            if (!ended) begin
                push(t, loop_m, 1'b1, NSTEPS - 1, prev_note, 1'b0);
                t++;
                prev_clk = 1'b0;
            end
        end
        idle_from = loop_m ? 32'h3fff_ffff : t;
    endtask

    // Drive one cycle of inputs and update the reference model.
    task automatic tick(input bit st, input bit sp, input bit we,
                        input logic [3:0] wa, input logic [7:0] wd);
        int c;
        @(posedge clk);
        #1;
        start_i   = st;
        stop_i    = sp;
        wr_en_i   = we;
        wr_addr_i = wa;
        wr_data_i = wd;
        c = cyc;
        if (we && c >= idle_from) mram[wa] = wd;
        if (sp) begin
            while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
            if (idle_from > c + 1) idle_from = c + 1;
            push(c + 1, 1'b0, 1'b0, 0, 0, 1'b0);
        end else if (st && c >= idle_from) begin
            gen_trace(c);
        end else if (c + 1 >= idle_from) begin
            push(c + 1, 1'b0, 1'b0, 0, 0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        tick(1'b0, 1'b0, 1'b1, 4'(a), d);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        wr_en_i = 1'b0;
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_from = cyc;
    endtask

    // Monitor: all comparisons and the summary live here.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b0 || step_o !== 4'd0 ||
                note_o !== 4'd0 || clk_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_state t=%0t got busy=%0b done=%0b step=%0d note=%0d clk=%0b want all 0",
                         $time, busy_o, done_o, step_o, note_o, clk_o);
            end
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d got none want cyc=%0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (busy_o !== e.busy || done_o !== e.done || step_o !== e.step ||
                    note_o !== e.note || clk_o !== e.clk) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got busy=%0b done=%0b step=%0d note=%0d clk=%0b want busy=%0b done=%0b step=%0d note=%0d clk=%0b",
                             cyc, busy_o, done_o, step_o, note_o, clk_o,
                             e.busy, e.done, e.step, e.note, e.clk);
                end
            end
            if (end_req) begin
                checks++;
                if (sb.size() > 1) begin
                    errors++;
                    $display("FAIL trace_drained got %0d pending want at most 1", sb.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no end of test want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_from = cyc;

        for (int i = 0; i < NSTEPS; i++) wr(i, 8'h00);

        // Single F#3 beat then end marker.
        wr(0, 8'h71); wr(1, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(14);

        // Two-beat rest, one A3 beat, end marker.
        wr(0, 8'h02); wr(1, 8'hA1); wr(2, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(32);

        // Abort five cycles into the A3 note.
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(22);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        idle(4);

        // start and write while busy are ignored; replay shows old RAM[0].
        wr(0, 8'h33); wr(1, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        tick(1'b0, 1'b0, 1'b1, 4'd0, 8'h55);
        idle(30);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(30);

        // stop beats start in the same idle cycle.
        tick(1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
        idle(3);

        // Write and start together: playback uses the new entry.
        tick(1'b1, 1'b0, 1'b1, 4'd0, 8'h92);
        idle(25);

        // All sixteen entries, one beat each, no end marker.
        for (int i = 0; i < NSTEPS; i++) wr(i, {4'($urandom_range(0, 15)), 4'd1});
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(150);

        // Random songs with random start/stop/write traffic.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NSTEPS; i++) begin
                logic [3:0] b;
                b = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                wr(i, {4'($urandom_range(0, 15)), b});
            end
            for (int n = 0; n < 420; n++) begin
                tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0),
                     ($urandom_range(0, 9) == 0), 4'($urandom), 8'($urandom));
            end
            tick(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
            idle(2);
        end

        // Asynchronous reset in the middle of a note.
        wr(0, 8'h51); wr(1, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(4);
        reset_mid();
        idle(3);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(12);

`ifdef LOOP_EN
        // Two-entry song repeating until stop.
        wr(0, 8'h41); wr(1, 8'h61); wr(2, 8'h00);
        loop_m = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(70);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        loop_m = 1'b0;
        idle(3);
`endif

        end_req = 1'b1;
        repeat (3) @(posedge clk);
    end

endmodule
